freq_meter: RTL and testbench

Gated frequency/period meter for the divided-clock and generated-signal paths. It samples an asynchronous slow signal, such as a divided clock or an external generator output, in the `clk` domain. It counts rising edges over a programmable gate window and reports the clock-cycle span between the first and last edge in that window. It is the measuring counterpart to the clock dividers and is used to check their output frequency in-system.

---
 rtl/freq_meter_pkg.sv | 10 +
 rtl/sync_edge_det.sv | 27 ++
 rtl/freq_meter.sv | 133 +++++++++++++
 tb/tb_freq_meter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types for the gated frequency/period meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous input into clk and flags its rising edges.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over a fixed window
// and reports the cycle span between the first and last edge.
//
// state | meaning
// IDLE  | waiting for start; results hold
// GATE  | window open, gate_cnt running, edges counted
// DONE  | one-cycle dead time; results and meas_valid presented
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 1_000_000,
  parameter int CNT_W       = 32,
  parameter int EDGE_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig_in,
  input  logic              start,
  input  logic              cont,
  output logic              busy,
  output logic              meas_valid,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [CNT_W-1:0]  span,
  output logic              ovf
);

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);

  state_t            state;
  logic              rise;
  logic [CNT_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]  first_t, last_t, first_nx, last_nx;
  logic [EDGE_W-1:0] edge_w, edge_nx;
  logic              seen, seen_nx;
  logic              ovf_w, ovf_nx;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig_in),
    .rise(rise)
  );

  // Working-counter update for this cycle; the final gate cycle's edge is
  // folded straight into the results so they appear in the DONE cycle.
  always_comb begin
    edge_nx  = edge_w;
    ovf_nx   = ovf_w;
    first_nx = first_t;
    last_nx  = last_t;
    seen_nx  = seen;
    if (state == GATE && rise) begin
      if (&edge_w) ovf_nx = 1'b1;
      else         edge_nx = edge_w + EDGE_W'(1);
      if (!seen) begin
        first_nx = gate_cnt;
        seen_nx  = 1'b1;
      end
      last_nx = gate_cnt;
    end
  end

  // Measurement FSM with working counters and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      meas_valid <= 1'b0;
      edge_cnt   <= '0;
      span       <= '0;
      ovf        <= 1'b0;
      gate_cnt   <= '0;
      edge_w     <= '0;
      first_t    <= '0;
      last_t     <= '0;
      seen       <= 1'b0;
      ovf_w      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= GATE;
            busy     <= 1'b1;
            gate_cnt <= '0;
            edge_w   <= '0;
            first_t  <= '0;
            last_t   <= '0;
            seen     <= 1'b0;
            ovf_w    <= 1'b0;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + CNT_W'(1);
          edge_w   <= edge_nx;
          first_t  <= first_nx;
          last_t   <= last_nx;
          seen     <= seen_nx;
          ovf_w    <= ovf_nx;
          if (gate_cnt == GATE_LAST) begin
            state      <= DONE;
            meas_valid <= 1'b1;
            edge_cnt   <= edge_nx;
            span       <= (edge_nx > EDGE_W'(1)) ? (last_nx - first_nx) : '0;
            ovf        <= ovf_nx;
          end
        end
        DONE: begin
          if (cont) begin
            state    <= GATE;
            gate_cnt <= '0;
            edge_w   <= '0;
            first_t  <= '0;
            last_t   <= '0;
            seen     <= 1'b0;
            ovf_w    <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: default instance plus a 4-bit edge
// counter instance for saturation.
module tb_freq_meter;
  localparam int GC = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0, start = 1'b0, cont = 1'b0;
  logic        busy, mv, ovf;
  logic [31:0] edge_cnt, span;
  logic        sig4 = 1'b0, start4 = 1'b0, cont4 = 1'b0;
  logic        busy4, mv4, ovf4;
  logic [3:0]  edge_cnt4;
  logic [31:0] span4;

  int n_tests = 0;
  int n_fail  = 0;
  int per  = 0;
  int per4 = 0;
  int ph   = 0;

  typedef struct {
    logic [31:0] e;
    logic [31:0] s;
    logic        o;
    int          cyc;
  } exp_t;
  exp_t q[$];

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .EDGE_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy), .meas_valid(mv), .edge_cnt(edge_cnt), .span(span), .ovf(ovf));

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(32), .EDGE_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig4), .start(start4), .cont(cont4),
    .busy(busy4), .meas_valid(mv4), .edge_cnt(edge_cnt4), .span(span4), .ovf(ovf4));

  always #5 clk = ~clk;

  // Square-wave generators, changing shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    ph = ph + 1;
    if (per > 0)  sig_in = (ph % per)  < (per / 2);
    if (per4 > 0) sig4   = (ph % per4) < (per4 / 2);
  end

  task automatic do_start(input bit sel);
    @(negedge clk);
    if (sel) start4 = 1'b1; else start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start4 = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after the call) of the next
  // meas_valid, or 0 if none within budget.
  task automatic wait_valid(input bit sel, input int budget, output int cyc);
    cyc = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((sel ? mv4 : mv) === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (busy !== 1'b0 || mv !== 1'b0 || edge_cnt !== 32'd0 || span !== 32'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b mv=%b edge=%0d span=%0d ovf=%b, want all 0",
               busy, mv, edge_cnt, span, ovf);
    end
    n_tests++;
    if (busy4 !== 1'b0 || mv4 !== 1'b0 || edge_cnt4 !== 4'd0 || ovf4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs4: busy=%b mv=%b edge=%0d ovf=%b, want all 0",
               busy4, mv4, edge_cnt4, ovf4);
    end
  endtask

  task automatic test_basic();
    int cyc;
    exp_t ex;
    per = 10;
    repeat (30) @(negedge clk);
    q.push_back('{e: 32'd10, s: 32'd90, o: 1'b0, cyc: GC + 1});
    do_start(0);
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_gate: got %b want 1", busy); end
    wait_valid(0, 300, cyc);
    cyc = cyc + 1;
    ex = q.pop_front();
    n_tests++;
    if (cyc !== ex.cyc) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", cyc, ex.cyc); end
    n_tests++;
    if (edge_cnt !== ex.e || span !== ex.s || ovf !== ex.o) begin
      n_fail++;
      $display("FAIL basic_result: got edge=%0d span=%0d ovf=%b want %0d/%0d/%b",
               edge_cnt, span, ovf, ex.e, ex.s, ex.o);
    end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_done: got %b want 1", busy); end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || mv !== 1'b0) begin
      n_fail++; $display("FAIL basic_after: busy=%b mv=%b want 0/0", busy, mv);
    end
  endtask

  task automatic test_no_edges();
    int cyc;
    exp_t ex;
    per = 0;
    sig_in = 1'b0;
    repeat (10) @(negedge clk);
    q.push_back('{e: 32'd0, s: 32'd0, o: 1'b0, cyc: GC + 1});
    do_start(0);
    wait_valid(0, 300, cyc);
    ex = q.pop_front();
    n_tests++;
    if (cyc !== ex.cyc) begin n_fail++; $display("FAIL noedge_latency: got %0d want %0d", cyc, ex.cyc); end
    n_tests++;
    if (edge_cnt !== ex.e || span !== ex.s || ovf !== ex.o) begin
      n_fail++;
      $display("FAIL noedge_result: got edge=%0d span=%0d ovf=%b want 0/0/0", edge_cnt, span, ovf);
    end
    wait_valid(0, 250, cyc);
    n_tests++;
    if (cyc !== 0) begin n_fail++; $display("FAIL noedge_extra_pulse: got pulse at %0d want none", cyc); end
  endtask

  task automatic test_single_edge();
    int cyc;
    exp_t ex;
    q.push_back('{e: 32'd1, s: 32'd0, o: 1'b0, cyc: GC + 1});
    do_start(0);
    repeat (29) @(negedge clk);
    sig_in = 1'b1;
    wait_valid(0, 300, cyc);
    cyc = cyc + 29;
    ex = q.pop_front();
    n_tests++;
    if (cyc !== ex.cyc) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", cyc, ex.cyc); end
    n_tests++;
    if (edge_cnt !== ex.e || span !== ex.s || ovf !== ex.o) begin
      n_fail++;
      $display("FAIL single_result: got edge=%0d span=%0d ovf=%b want 1/0/0", edge_cnt, span, ovf);
    end
    sig_in = 1'b0;
  endtask

  task automatic test_ovf();
    int cyc;
    exp_t ex;
    per4 = 4;
    repeat (20) @(negedge clk);
    q.push_back('{e: 32'd15, s: 32'd96, o: 1'b1, cyc: GC + 1});
    do_start(1);
    wait_valid(1, 300, cyc);
    ex = q.pop_front();
    n_tests++;
    if (cyc !== ex.cyc || {28'd0, edge_cnt4} !== ex.e || span4 !== ex.s || ovf4 !== ex.o) begin
      n_fail++;
      $display("FAIL ovf_result: got cyc=%0d edge=%0d span=%0d ovf=%b want %0d/%0d/%0d/%b",
               cyc, edge_cnt4, span4, ovf4, ex.cyc, ex.e, ex.s, ex.o);
    end
    per4 = 10;
    repeat (20) @(negedge clk);
    q.push_back('{e: 32'd10, s: 32'd90, o: 1'b0, cyc: GC + 1});
    do_start(1);
    wait_valid(1, 300, cyc);
    ex = q.pop_front();
    n_tests++;
    if (cyc !== ex.cyc || {28'd0, edge_cnt4} !== ex.e || span4 !== ex.s || ovf4 !== ex.o) begin
      n_fail++;
      $display("FAIL ovf_clear: got cyc=%0d edge=%0d span=%0d ovf=%b want %0d/%0d/%0d/%b",
               cyc, edge_cnt4, span4, ovf4, ex.cyc, ex.e, ex.s, ex.o);
    end
    per4 = 0;
    sig4 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_t ex;
    per = 10;
    cont = 1'b1;
    for (int w = 0; w < 3; w++)
      q.push_back('{e: 32'd10, s: 32'd90, o: 1'b0, cyc: GC + 1});
    do_start(0);
    for (int w = 0; w < 3; w++) begin
      if (w == 2) begin
        wait_valid(0, 20, cyc);
        n_tests++;
        if (cyc !== 0) begin n_fail++; $display("FAIL cont_early_pulse: got %0d want none", cyc); end
        cont = 1'b0;
        wait_valid(0, 300, cyc);
        cyc = cyc + 20;
      end else begin
        wait_valid(0, 300, cyc);
      end
      ex = q.pop_front();
      n_tests++;
      if (cyc !== ex.cyc || edge_cnt !== ex.e || span !== ex.s || ovf !== ex.o) begin
        n_fail++;
        $display("FAIL cont_window%0d: got cyc=%0d edge=%0d span=%0d ovf=%b want %0d/%0d/%0d/%b",
                 w, cyc, edge_cnt, span, ovf, ex.cyc, ex.e, ex.s, ex.o);
      end
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop_busy: got %b want 0", busy); end
    wait_valid(0, 150, cyc);
    n_tests++;
    if (cyc !== 0) begin n_fail++; $display("FAIL cont_stop_pulse: got %0d want none", cyc); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    exp_t ex;
    per = 10;
    do_start(0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || mv !== 1'b0 || edge_cnt !== 32'd0 || span !== 32'd0 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: busy=%b mv=%b edge=%0d span=%0d ovf=%b want all 0",
               busy, mv, edge_cnt, span, ovf);
    end
    wait_valid(0, 150, cyc);
    n_tests++;
    if (cyc !== 0) begin n_fail++; $display("FAIL midrst_pulse: got %0d want none", cyc); end
    q.push_back('{e: 32'd10, s: 32'd90, o: 1'b0, cyc: GC + 1});
    do_start(0);
    wait_valid(0, 300, cyc);
    ex = q.pop_front();
    n_tests++;
    if (cyc !== ex.cyc || edge_cnt !== ex.e || span !== ex.s || ovf !== ex.o) begin
      n_fail++;
      $display("FAIL midrst_restart: got cyc=%0d edge=%0d span=%0d ovf=%b want %0d/%0d/%0d/%b",
               cyc, edge_cnt, span, ovf, ex.cyc, ex.e, ex.s, ex.o);
    end
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_no_edges();
    test_single_edge();
    test_ovf();
    test_back_to_back();
    test_reset_mid();
    n_tests++;
    if (q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d left want 0", q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
